// File: rtl/bp_be_scoreboard_counted.sv
`default_nettype none
// ============================================================================
// Module : bp_be_scoreboard_counted
// Brief  : Per-register counted late-writeback scoreboard with killable scores.
// Rev    : 1.0  initial release
// ============================================================================
module bp_be_scoreboard_counted #(
  parameter int num_regs_p       = 32,
  parameter int reg_addr_width_p = 5,
  parameter int num_rs_p         = 3,
  parameter int num_score_p      = 2,
  parameter int num_clear_p      = 2,
  parameter int cnt_width_p      = 2,
  parameter int spec_stages_p    = 2,
  parameter bit zero_reg_p       = 1'b1,
  parameter bit clear_bypass_p   = 1'b1
) (
  input  logic                                    clk_i,
  input  logic                                    reset_n_i,
  input  logic [num_score_p-1:0]                  score_v_i,
  input  logic [num_score_p*reg_addr_width_p-1:0] score_rd_i,
  output logic                                    score_ready_o,
  input  logic [num_clear_p-1:0]                  clear_v_i,
  input  logic [num_clear_p*reg_addr_width_p-1:0] clear_rd_i,
  input  logic                                    kill_i,
  input  logic [num_rs_p*reg_addr_width_p-1:0]    rs_i,
  input  logic [reg_addr_width_p-1:0]             rd_i,
  output logic [num_rs_p-1:0]                     rs_match_o,
  output logic                                    rd_match_o,
  output logic                                    busy_o,
  output logic                                    error_o
);

  localparam int c_net_w = cnt_width_p + 2;
  // Stage 0 of the speculative window is the acceptance cycle itself, which kill
  // covers by refusing the score, so only the later stages need storage.
  localparam int c_depth    = (spec_stages_p > 1) ? spec_stages_p - 1 : 1;
  localparam bit c_has_pipe = (spec_stages_p > 1);
  localparam logic signed [c_net_w-1:0] c_cnt_max = c_net_w'((1 << cnt_width_p) - 1);
  localparam logic [c_net_w-1:0]        c_one     = c_net_w'(1);

  logic [cnt_width_p-1:0]      r_cnt     [num_regs_p];
  logic [num_score_p-1:0]      r_spec_v  [c_depth];
  logic [reg_addr_width_p-1:0] r_spec_rd [c_depth][num_score_p];
  logic                        r_error;

  logic [reg_addr_width_p-1:0] w_score_rd [num_score_p];
  logic [reg_addr_width_p-1:0] w_clear_rd [num_clear_p];
  logic [reg_addr_width_p-1:0] w_rs       [num_rs_p];
  logic [c_net_w-1:0]          w_nclr     [num_regs_p];
  logic [c_net_w-1:0]          w_nreq     [num_regs_p];
  logic [c_net_w-1:0]          w_nacc     [num_regs_p];
  logic [c_net_w-1:0]          w_nkill    [num_regs_p];
  logic signed [c_net_w-1:0]   w_req      [num_regs_p];
  logic signed [c_net_w-1:0]   w_net      [num_regs_p];
  logic [cnt_width_p-1:0]      w_cnt_nxt  [num_regs_p];
  logic [num_score_p-1:0]      w_score_acc;
  logic                        w_ready;
  logic                        w_clr_zero;
  logic                        w_underflow;
  logic                        w_busy;

  genvar g;
  generate
    for (g = 0; g < num_score_p; g++) begin : g_score_rd
      assign w_score_rd[g]  = score_rd_i[g*reg_addr_width_p +: reg_addr_width_p];
      assign w_score_acc[g] = score_v_i[g] & w_ready & ~kill_i
                              & ~(zero_reg_p && (w_score_rd[g] == '0));
    end
    for (g = 0; g < num_clear_p; g++) begin : g_clear_rd
      assign w_clear_rd[g] = clear_rd_i[g*reg_addr_width_p +: reg_addr_width_p];
    end
    for (g = 0; g < num_rs_p; g++) begin : g_rs_match
      assign w_rs[g] = rs_i[g*reg_addr_width_p +: reg_addr_width_p];
      assign rs_match_o[g] = (r_cnt[w_rs[g]] != '0)
                             && !(zero_reg_p && (w_rs[g] == '0))
                             && !(clear_bypass_p && ({2'b00, r_cnt[w_rs[g]]} == w_nclr[w_rs[g]]));
    end
  endgenerate

  assign rd_match_o = (r_cnt[rd_i] != '0)
                      && !(zero_reg_p && (rd_i == '0))
                      && !(clear_bypass_p && ({2'b00, r_cnt[rd_i]} == w_nclr[rd_i]));

  // Ready is all-or-none: any register that would overflow blocks every port.
  always_comb begin
    w_ready    = 1'b1;
    w_clr_zero = 1'b0;
    for (int c = 0; c < num_clear_p; c++) begin
      if (zero_reg_p && clear_v_i[c] && (w_clear_rd[c] == '0)) w_clr_zero = 1'b1;
    end
    for (int r = 0; r < num_regs_p; r++) begin
      w_nclr[r] = '0;
      w_nreq[r] = '0;
      for (int c = 0; c < num_clear_p; c++) begin
        if (clear_v_i[c] && (w_clear_rd[c] == reg_addr_width_p'(r))) w_nclr[r] = w_nclr[r] + c_one;
      end
      for (int p = 0; p < num_score_p; p++) begin
        if (score_v_i[p] && (w_score_rd[p] == reg_addr_width_p'(r))
            && !(zero_reg_p && (r == 0))) w_nreq[r] = w_nreq[r] + c_one;
      end
      w_req[r] = $signed({2'b00, r_cnt[r]}) + $signed(w_nreq[r]) - $signed(w_nclr[r]);
      if (w_req[r] > c_cnt_max) w_ready = 1'b0;
    end
  end

  always_comb begin
    w_underflow = 1'b0;
    w_busy      = 1'b0;
    for (int r = 0; r < num_regs_p; r++) begin
      w_nacc[r]  = '0;
      w_nkill[r] = '0;
      for (int p = 0; p < num_score_p; p++) begin
        if (w_score_acc[p] && (w_score_rd[p] == reg_addr_width_p'(r))) w_nacc[r] = w_nacc[r] + c_one;
        for (int s = 0; s < c_depth; s++) begin
          if (kill_i && r_spec_v[s][p] && (r_spec_rd[s][p] == reg_addr_width_p'(r)))
            w_nkill[r] = w_nkill[r] + c_one;
        end
      end
      w_net[r] = $signed({2'b00, r_cnt[r]}) + $signed(w_nacc[r])
                 - $signed(w_nclr[r]) - $signed(w_nkill[r]);
      if (w_net[r] < 0) begin
        w_underflow  = 1'b1;
        w_cnt_nxt[r] = '0;
      end else begin
        w_cnt_nxt[r] = w_net[r][cnt_width_p-1:0];
      end
      if (r_cnt[r] != '0) w_busy = 1'b1;
    end
    for (int s = 0; s < c_depth; s++) begin
      if (r_spec_v[s] != '0) w_busy = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int r = 0; r < num_regs_p; r++) r_cnt[r] <= '0;
      for (int s = 0; s < c_depth; s++) begin
        r_spec_v[s] <= '0;
        for (int p = 0; p < num_score_p; p++) r_spec_rd[s][p] <= '0;
      end
      r_error <= 1'b0;
    end else begin
      for (int r = 0; r < num_regs_p; r++) r_cnt[r] <= w_cnt_nxt[r];
      r_spec_v[0] <= c_has_pipe ? w_score_acc : '0;
      for (int p = 0; p < num_score_p; p++) r_spec_rd[0][p] <= w_score_rd[p];
      for (int s = 1; s < c_depth; s++) begin
        r_spec_v[s] <= kill_i ? '0 : r_spec_v[s-1];
        for (int p = 0; p < num_score_p; p++) r_spec_rd[s][p] <= r_spec_rd[s-1][p];
      end
      r_error <= r_error | w_underflow | w_clr_zero | ((|score_v_i) & ~w_ready);
    end
  end

  assign score_ready_o = w_ready;
  assign busy_o        = w_busy;
  assign error_o       = r_error;

endmodule
`default_nettype wire

// File: tb/tb_bp_be_scoreboard_counted.sv
`default_nettype none
// ============================================================================
// Module : tb_bp_be_scoreboard_counted
// Brief  : Directed and random checks of the counted scoreboard against a queue model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_bp_be_scoreboard_counted;
  localparam int NR = 32, AW = 5, NRS = 3, NS = 2, NC = 2, CW = 2, SS = 2;
  localparam int MAXC = (1 << CW) - 1;

  logic              clk_i = 1'b0;
  logic              reset_n_i;
  logic [NS-1:0]     score_v_i;
  logic [NS*AW-1:0]  score_rd_i;
  logic              score_ready_o;
  logic [NC-1:0]     clear_v_i;
  logic [NC*AW-1:0]  clear_rd_i;
  logic              kill_i;
  logic [NRS*AW-1:0] rs_i;
  logic [AW-1:0]     rd_i;
  logic [NRS-1:0]    rs_match_o;
  logic              rd_match_o;
  logic              busy_o;
  logic              error_o;

  always #5 clk_i = ~clk_i;

  bp_be_scoreboard_counted #(
    .num_regs_p(NR), .reg_addr_width_p(AW), .num_rs_p(NRS), .num_score_p(NS),
    .num_clear_p(NC), .cnt_width_p(CW), .spec_stages_p(SS),
    .zero_reg_p(1'b1), .clear_bypass_p(1'b1)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .score_v_i(score_v_i), .score_rd_i(score_rd_i), .score_ready_o(score_ready_o),
    .clear_v_i(clear_v_i), .clear_rd_i(clear_rd_i), .kill_i(kill_i),
    .rs_i(rs_i), .rd_i(rd_i), .rs_match_o(rs_match_o), .rd_match_o(rd_match_o),
    .busy_o(busy_o), .error_o(error_o)
  );

  // Reference model: outstanding count per register plus a list of killable scores with age.
  int m_cnt[NR];
  int q_rd[$];
  int q_age[$];
  bit m_err;
  int checks = 0;
  int errors = 0;

  bit [NS-1:0] s_v;
  int          s_rd[NS];
  bit [NC-1:0] c_v;
  int          c_rd[NC];
  bit          s_kill;
  int          s_rs[NRS];
  int          s_rdq;

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic int n_clr(input int r);
    int n = 0;
    for (int c = 0; c < NC; c++) if (c_v[c] && c_rd[c] == r) n++;
    return n;
  endfunction

  function automatic int n_pending(input int r);
    int n = 0;
    foreach (q_rd[k]) if (q_rd[k] == r) n++;
    return n;
  endfunction

  function automatic bit m_ready();
    for (int r = 0; r < NR; r++) begin
      int n = m_cnt[r] - n_clr(r);
      for (int p = 0; p < NS; p++) if (s_v[p] && s_rd[p] == r && r != 0) n++;
      if (n > MAXC) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic bit m_match(input int a);
    return (a != 0) && (m_cnt[a] != 0) && (m_cnt[a] != n_clr(a));
  endfunction

  function automatic bit m_busy();
    if (q_rd.size() != 0) return 1'b1;
    for (int r = 0; r < NR; r++) if (m_cnt[r] != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic set_idle();
    s_v = '0; c_v = '0; s_kill = 1'b0; s_rdq = 0;
    for (int p = 0; p < NS; p++) s_rd[p] = 0;
    for (int c = 0; c < NC; c++) c_rd[c] = 0;
    for (int i = 0; i < NRS; i++) s_rs[i] = 0;
  endtask

  // Drive one cycle, compare combinational outputs mid-cycle, then advance model and clock.
  task automatic cycle();
    bit rdy;
    int net[NR];
    int new_rd[$];
    int nq_rd[$];
    int nq_age[$];
    score_v_i = s_v; clear_v_i = c_v; kill_i = s_kill; rd_i = AW'(s_rdq);
    for (int p = 0; p < NS; p++) score_rd_i[p*AW +: AW] = AW'(s_rd[p]);
    for (int c = 0; c < NC; c++) clear_rd_i[c*AW +: AW] = AW'(c_rd[c]);
    for (int i = 0; i < NRS; i++) rs_i[i*AW +: AW] = AW'(s_rs[i]);
    #2;
    rdy = m_ready();
    check("score_ready", score_ready_o, rdy);
    for (int i = 0; i < NRS; i++) check($sformatf("rs_match[%0d]", i), rs_match_o[i], m_match(s_rs[i]));
    check("rd_match", rd_match_o, m_match(s_rdq));
    check("busy", busy_o, m_busy());
    check("error", error_o, m_err);

    if (s_v != '0 && !rdy) m_err = 1'b1;
    net = m_cnt;
    for (int p = 0; p < NS; p++) begin
      if (s_v[p] && rdy && !s_kill && s_rd[p] != 0) begin
        net[s_rd[p]]++;
        new_rd.push_back(s_rd[p]);
      end
    end
    for (int c = 0; c < NC; c++) begin
      if (c_v[c]) begin
        net[c_rd[c]]--;
        if (c_rd[c] == 0) m_err = 1'b1;
      end
    end
    if (s_kill) begin
      foreach (q_rd[k]) net[q_rd[k]]--;
    end else begin
      foreach (q_rd[k]) if (q_age[k] + 1 <= SS - 1) begin
        nq_rd.push_back(q_rd[k]);
        nq_age.push_back(q_age[k] + 1);
      end
    end
    if (SS > 1) foreach (new_rd[k]) begin
      nq_rd.push_back(new_rd[k]);
      nq_age.push_back(1);
    end
    q_rd = nq_rd;
    q_age = nq_age;
    for (int r = 0; r < NR; r++) begin
      if (net[r] < 0) begin
        m_err = 1'b1;
        net[r] = 0;
      end
    end
    m_cnt = net;
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    set_idle();
    score_v_i = '0; score_rd_i = '0; clear_v_i = '0; clear_rd_i = '0;
    kill_i = 1'b0; rs_i = '0; rd_i = '0;
    reset_n_i = 1'b0;
    for (int r = 0; r < NR; r++) m_cnt[r] = 0;
    q_rd.delete();
    q_age.delete();
    m_err = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    reset_n_i = 1'b1;
    #1;
  endtask

  task automatic score1(input int rd);
    set_idle(); s_v[0] = 1'b1; s_rd[0] = rd; s_rs[0] = rd; s_rdq = rd; cycle();
  endtask

  task automatic clear1(input int rd);
    set_idle(); c_v[0] = 1'b1; c_rd[0] = rd; s_rs[0] = rd; s_rdq = rd; cycle();
  endtask

  task automatic idle_on(input int rd);
    set_idle(); s_rs[0] = rd; s_rdq = rd; cycle();
  endtask

  initial begin
    do_reset();
    check("rst_ready", score_ready_o, 1'b1);
    check("rst_busy", busy_o, 1'b0);
    check("rst_error", error_o, 1'b0);
    check("rst_rd_match", rd_match_o, 1'b0);
    check("rst_rs_match", |rs_match_o, 1'b0);

    // Score rd5, visible next cycle, bypassed away on its clear cycle.
    score1(5);
    check("rd5_visible", rs_match_o[0], 1'b1);
    idle_on(5); idle_on(5);
    clear1(5);
    idle_on(5);

    // Fill rd7 to the limit, then score+clear together keeps it full and ready.
    score1(7); score1(7); score1(7);
    set_idle(); s_v[0] = 1'b1; s_rd[0] = 7; c_v[0] = 1'b1; c_rd[0] = 7; s_rs[0] = 7; cycle();
    idle_on(7); idle_on(7);
    clear1(7); clear1(7); clear1(7);
    idle_on(7);

    // Kill inside the window removes the score; after the window it sticks.
    score1(9);
    set_idle(); s_kill = 1'b1; s_rs[0] = 9; cycle();
    idle_on(9);
    check("rd9_killed", rs_match_o[0], 1'b0);
    score1(9);
    idle_on(9);
    set_idle(); s_kill = 1'b1; s_rs[0] = 9; cycle();
    idle_on(9);
    check("rd9_committed", rs_match_o[0], 1'b1);
    clear1(9);

    // Two scores and one clear on rd4 with cnt=1 leave cnt=2.
    score1(4); idle_on(4);
    set_idle(); s_v = 2'b11; s_rd[0] = 4; s_rd[1] = 4; c_v[0] = 1'b1; c_rd[0] = 4; s_rs[0] = 4; cycle();
    idle_on(4); idle_on(4);
    set_idle(); c_v = 2'b11; c_rd[0] = 4; c_rd[1] = 4; s_rs[0] = 4; cycle();
    idle_on(4);

    // Random traffic kept legal so that error_o must stay low.
    for (int n = 0; n < 400; n++) begin
      set_idle();
      s_kill = ($urandom_range(0, 7) == 0);
      if (!s_kill) begin
        for (int c = 0; c < NC; c++) begin
          if ($urandom_range(0, 1) == 1) begin
            int r = $urandom_range(1, 7);
            if (m_cnt[r] - n_pending(r) - n_clr(r) > 0) begin
              c_v[c] = 1'b1;
              c_rd[c] = r;
            end
          end
        end
      end
      for (int p = 0; p < NS; p++) begin
        s_v[p] = ($urandom_range(0, 1) == 1);
        s_rd[p] = $urandom_range(0, 7);
      end
      if (!m_ready()) s_v = '0;
      for (int i = 0; i < NRS; i++) s_rs[i] = $urandom_range(0, 7);
      s_rdq = $urandom_range(0, 7);
      cycle();
    end

    // Fourth score to a full register is refused and flagged.
    do_reset();
    score1(7); score1(7); score1(7);
    score1(7);
    idle_on(7);
    check("overflow_err", error_o, 1'b1);

    // Clearing an empty register flags an error; scores to reg 0 are dropped.
    do_reset();
    clear1(3);
    idle_on(3);
    check("underflow_err", error_o, 1'b1);
    score1(0);
    idle_on(0);
    check("zero_reg_match", rs_match_o[0], 1'b0);
    idle_on(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
